// File: rtl/pwm_pkg.sv
// ---------------------------------------------------------------------------
// pwm_pkg
// Shared types and helpers for the RGB PWM sequencer.
//   pwm_mode_t     : run mode decode of the 2-bit mode input
//   tri_wave       : triangle wave of a (W+1)-bit phase, W-bit result
//   channel_offset : phase offset of channel k, k*floor(2^(W+1)/channels)
// No ports; imported by rgb_pwm_sequencer and pwm_channel.
// ---------------------------------------------------------------------------
package pwm_pkg;

    typedef enum logic [1:0] {
        CYCLE  = 2'd0,
        HOLD   = 2'd1,
        MANUAL = 2'd2,
        OFF    = 2'd3
    } pwm_mode_t;

    // Rising half returns t, falling half mirrors it so the peak value
    // 2^w-1 appears twice and the wave is symmetric over 2^(w+1) steps.
    function automatic int unsigned tri_wave(input int unsigned t,
                                             input int unsigned w);
        int unsigned half;
        half = 32'd1 << w;
        if (t < half) begin
            return t;
        end
        return (half << 1) - 32'd1 - t;
    endfunction

    function automatic int unsigned channel_offset(input int unsigned k,
                                                   input int unsigned channels,
                                                   input int unsigned w);
        return k * ((32'd1 << (w + 32'd1)) / channels);
    endfunction

endpackage

// File: rtl/pwm_channel.sv
// ---------------------------------------------------------------------------
// pwm_channel
// One PWM output. Latches its duty only at the frame wrap so a frame is
// never cut short or stretched, and registers the compare result.
//   clk        in  : system clock
//   reset      in  : synchronous, active-high
//   cnt        in  : shared PWM counter
//   frame_wrap in  : high on the cycle where cnt = 2^W-1
//   force_off  in  : drive the inactive level from the next edge
//   duty_next  in  : duty to latch at the next frame wrap
//   pwm        out : LED drive, inverted when ACTIVE_LOW
// ---------------------------------------------------------------------------
module pwm_channel
    import pwm_pkg::*;
#(
    parameter int unsigned PWM_WIDTH  = 8,
    parameter bit          ACTIVE_LOW = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [PWM_WIDTH-1:0] cnt,
    input  logic                 frame_wrap,
    input  logic                 force_off,
    input  logic [PWM_WIDTH-1:0] duty_next,
    output logic                 pwm
);

    logic [PWM_WIDTH-1:0] duty_q;
    logic                 active;

    always_ff @(posedge clk) begin
        if (reset) begin
            duty_q <= '0;
        end else if (frame_wrap) begin
            duty_q <= duty_next;
        end
    end

    // force_off gates the pin directly; duty_q itself is only cleared at
    // the next wrap through duty_next.
    always_comb begin
        active = 1'b0;
        if (!force_off && (cnt < duty_q)) begin
            active = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pwm <= ACTIVE_LOW;
        end else begin
            pwm <= active ^ ACTIVE_LOW;
        end
    end

endmodule

// File: rtl/rgb_pwm_sequencer.sv
// ---------------------------------------------------------------------------
// rgb_pwm_sequencer
// N-channel PWM colour sequencer. A shared hue phase advances once per
// STEP_CYCLES clocks in CYCLE mode; each channel's duty is a triangle wave
// of that phase, offset per channel, so the outputs fade through a colour
// cycle.
//   clk         in  : system clock (12 MHz)
//   reset       in  : synchronous, active-high
//   mode        in  : 0 CYCLE, 1 HOLD, 2 MANUAL, 3 OFF
//   duty_in     in  : manual duties, channel k at [k*W +: W]
//   pwm_out     out : LED drive per channel, polarity per ACTIVE_LOW
//   phase       out : current hue phase, W+1 bits
//   frame_start out : high while the PWM counter is 0
// ---------------------------------------------------------------------------
module rgb_pwm_sequencer
    import pwm_pkg::*;
#(
    parameter int unsigned CHANNELS    = 3,
    parameter int unsigned PWM_WIDTH   = 8,
    parameter int unsigned STEP_CYCLES = 23437,
    parameter bit          ACTIVE_LOW  = 1'b1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [1:0]                    mode,
    input  logic [CHANNELS*PWM_WIDTH-1:0] duty_in,
    output logic [CHANNELS-1:0]           pwm_out,
    output logic [PWM_WIDTH:0]            phase,
    output logic                          frame_start
);

    localparam int unsigned DIV_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;

    logic [PWM_WIDTH-1:0] cnt;
    logic [DIV_W-1:0]     div;
    logic                 tick;
    logic                 frame_wrap;
    logic                 force_off;
    pwm_mode_t            run_mode;

    assign run_mode    = pwm_mode_t'(mode);
    assign force_off   = (run_mode == OFF);
    assign tick        = (div == DIV_W'(STEP_CYCLES - 1));
    assign frame_wrap  = (cnt == '1);
    assign frame_start = (cnt == '0);

    // PWM counter: free-running, one frame per 2^W clocks.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Step divider runs in every mode so HOLD/OFF never disturb the
    // tick cadence when CYCLE resumes.
    always_ff @(posedge clk) begin
        if (reset) begin
            div <= '0;
        end else if (tick) begin
            div <= '0;
        end else begin
            div <= div + 1'b1;
        end
    end

    // Hue phase wraps naturally through its W+1 bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            phase <= '0;
        end else if (tick && (run_mode == CYCLE)) begin
            phase <= phase + 1'b1;
        end
    end

    for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
        localparam logic [PWM_WIDTH:0] OFFSET =
            (PWM_WIDTH + 1)'(channel_offset(k, CHANNELS, PWM_WIDTH));

        logic [PWM_WIDTH:0]   t;
        logic [PWM_WIDTH-1:0] duty_next;

        // Addition in W+1 bits gives the mod-PERIOD wrap for free.
        assign t = phase + OFFSET;

        always_comb begin
            duty_next = '0;
            case (run_mode)
                CYCLE, HOLD: duty_next = PWM_WIDTH'(tri_wave(32'(t), PWM_WIDTH));
                MANUAL:      duty_next = duty_in[k*PWM_WIDTH +: PWM_WIDTH];
                default:     duty_next = '0;
            endcase
        end

        pwm_channel #(
            .PWM_WIDTH  (PWM_WIDTH),
            .ACTIVE_LOW (ACTIVE_LOW)
        ) u_ch (
            .clk        (clk),
            .reset      (reset),
            .cnt        (cnt),
            .frame_wrap (frame_wrap),
            .force_off  (force_off),
            .duty_next  (duty_next),
            .pwm        (pwm_out[k])
        );
    end

endmodule

// File: tb/tb_rgb_pwm_sequencer.sv
// ---------------------------------------------------------------------------
// tb_rgb_pwm_sequencer
// Directed bench for rgb_pwm_sequencer with CHANNELS=3, W=3, STEP_CYCLES=4,
// ACTIVE_LOW=1 (PERIOD=16, offsets 0/5/10). Inputs change and outputs are
// sampled on the falling edge. Frame low counts are packed as
// ch2*100 + ch1*10 + ch0.
// ---------------------------------------------------------------------------
module tb_rgb_pwm_sequencer;
    import pwm_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] mode = CYCLE;
    logic [8:0] duty_in = '0;
    logic [2:0] pwm_out;
    logic [3:0] phase;
    logic       frame_start;

    int passed = 0;
    int total  = 0;

    rgb_pwm_sequencer #(
        .CHANNELS    (3),
        .PWM_WIDTH   (3),
        .STEP_CYCLES (4),
        .ACTIVE_LOW  (1'b1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .mode        (mode),
        .duty_in     (duty_in),
        .pwm_out     (pwm_out),
        .phase       (phase),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
    endtask

    // Counts low (on) clocks per channel over the 8 pin samples of a frame,
    // starting from the falling edge where cnt = 0.
    task automatic frame_lows(output int code);
        int l0, l1, l2;
        l0 = 0; l1 = 0; l2 = 0;
        repeat (8) begin
            @(negedge clk);
            if (pwm_out[0] == 1'b0) l0++;
            if (pwm_out[1] == 1'b0) l1++;
            if (pwm_out[2] == 1'b0) l2++;
        end
        code = l2 * 100 + l1 * 10 + l0;
    endtask

    task automatic test_reset();
        int code;
        mode = CYCLE; duty_in = '0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (pwm_out !== 3'b111) $display("FAIL reset_pwm got %b want 111", pwm_out); else passed++;
        total++; if (phase !== 4'd0) $display("FAIL reset_phase got %0d want 0", phase); else passed++;
        total++; if (frame_start !== 1'b1) $display("FAIL reset_frame_start got %b want 1", frame_start); else passed++;
        reset = 1'b0;
        frame_lows(code);
        total++; if (code !== 0) $display("FAIL reset_first_frame got %0d want 0", code); else passed++;
        total++; if (phase !== 4'd2) $display("FAIL reset_phase_8clk got %0d want 2", phase); else passed++;
        total++; if (frame_start !== 1'b1) $display("FAIL reset_frame2_start got %b want 1", frame_start); else passed++;
        // duty latched at the wrap uses pre-increment phase 1
        frame_lows(code);
        total++; if (code !== 461) $display("FAIL reset_second_frame got %0d want 461", code); else passed++;
        total++; if (phase !== 4'd4) $display("FAIL reset_phase_16clk got %0d want 4", phase); else passed++;
    endtask

    task automatic test_reset_hold();
        int code;
        mode = HOLD;
        do_reset();
        frame_lows(code);
        total++; if (code !== 0) $display("FAIL hold_first_frame got %0d want 0", code); else passed++;
        frame_lows(code);
        total++; if (code !== 550) $display("FAIL hold_phase0_frame got %0d want 550", code); else passed++;
        total++; if (phase !== 4'd0) $display("FAIL hold_phase0 got %0d want 0", phase); else passed++;
    endtask

    task automatic test_manual();
        int code;
        mode = MANUAL; duty_in = {3'd7, 3'd0, 3'd3};
        do_reset();
        frame_lows(code);
        frame_lows(code);
        total++; if (code !== 703) $display("FAIL manual_frame got %0d want 703", code); else passed++;
        total++; if (pwm_out !== 3'b111) $display("FAIL manual_at_frame_start got %b want 111", pwm_out); else passed++;
        @(negedge clk);
        total++; if (pwm_out !== 3'b010) $display("FAIL manual_first_sample got %b want 010", pwm_out); else passed++;
    endtask

    task automatic test_phase_sweep();
        mode = CYCLE; duty_in = '0;
        do_reset();
        for (int n = 1; n <= 64; n++) begin
            @(negedge clk);
            total++;
            if (phase !== 4'((n / 4) % 16)) $display("FAIL sweep_phase clk %0d got %0d want %0d", n, phase, (n / 4) % 16);
            else passed++;
        end
        total++; if (frame_start !== 1'b1) $display("FAIL sweep_frame_start got %b want 1", frame_start); else passed++;
    endtask

    task automatic test_hold();
        int code;
        mode = CYCLE;
        do_reset();
        repeat (32) @(negedge clk);
        total++; if (phase !== 4'd8) $display("FAIL hold_reach8 got %0d want 8", phase); else passed++;
        total++; if (frame_start !== 1'b1) $display("FAIL hold_reach8_start got %b want 1", frame_start); else passed++;
        mode = HOLD;
        frame_lows(code);
        total++; if (code !== 137) $display("FAIL hold_pre_inc_frame got %0d want 137", code); else passed++;
        frame_lows(code);
        total++; if (code !== 227) $display("FAIL hold_phase8_frame got %0d want 227", code); else passed++;
        total++; if (phase !== 4'd8) $display("FAIL hold_phase8_held got %0d want 8", phase); else passed++;
    endtask

    task automatic test_hold_off_resume();
        mode = CYCLE;
        do_reset();
        repeat (24) @(negedge clk);
        total++; if (phase !== 4'd6) $display("FAIL hor_reach6 got %0d want 6", phase); else passed++;
        mode = HOLD;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            total++; if (phase !== 4'd6) $display("FAIL hor_held clk %0d got %0d want 6", i, phase); else passed++;
        end
        @(negedge clk);
        total++; if (pwm_out !== 3'b100) $display("FAIL hor_before_off got %b want 100", pwm_out); else passed++;
        mode = OFF;
        @(negedge clk);
        total++; if (pwm_out !== 3'b111) $display("FAIL hor_off_next_edge got %b want 111", pwm_out); else passed++;
        repeat (4) @(negedge clk);
        total++; if (pwm_out !== 3'b111) $display("FAIL hor_off_steady got %b want 111", pwm_out); else passed++;
        total++; if (phase !== 4'd6) $display("FAIL hor_off_phase got %0d want 6", phase); else passed++;
        mode = CYCLE;
        @(negedge clk);
        total++; if (phase !== 4'd6) $display("FAIL hor_resume_wait got %0d want 6", phase); else passed++;
        @(negedge clk);
        total++; if (phase !== 4'd7) $display("FAIL hor_resume_tick got %0d want 7", phase); else passed++;
    endtask

    task automatic test_manual_change();
        int code, lows;
        mode = MANUAL; duty_in = {3'd0, 3'd0, 3'd2};
        do_reset();
        frame_lows(code);
        lows = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (pwm_out[0] == 1'b0) lows++;
            if (i == 2) duty_in = {3'd0, 3'd0, 3'd6};
        end
        total++; if (lows !== 2) $display("FAIL mchg_current_frame got %0d want 2", lows); else passed++;
        frame_lows(code);
        total++; if (code !== 6) $display("FAIL mchg_next_frame got %0d want 6", code); else passed++;
    endtask

    task automatic test_reset_mid();
        int code;
        mode = CYCLE; duty_in = '0;
        do_reset();
        repeat (36) @(negedge clk);
        total++; if (phase !== 4'd9) $display("FAIL rmid_phase9 got %0d want 9", phase); else passed++;
        total++; if (pwm_out !== 3'b110) $display("FAIL rmid_before got %b want 110", pwm_out); else passed++;
        reset = 1'b1;
        @(negedge clk);
        total++; if (phase !== 4'd0) $display("FAIL rmid_phase got %0d want 0", phase); else passed++;
        total++; if (frame_start !== 1'b1) $display("FAIL rmid_frame_start got %b want 1", frame_start); else passed++;
        total++; if (pwm_out !== 3'b111) $display("FAIL rmid_pwm got %b want 111", pwm_out); else passed++;
        reset = 1'b0;
        frame_lows(code);
        total++; if (code !== 0) $display("FAIL rmid_no_residual got %0d want 0", code); else passed++;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_reset_hold();
        test_manual();
        test_phase_sweep();
        test_hold();
        test_hold_off_resume();
        test_manual_change();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
